// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, port identifiers and byte-lane merge helper for the data-memory arbiter.
// Revision: 1.0
`default_nettype none

package dmem_pkg;

  localparam int WORD_AW = 8;
  localparam int BYTE_AW = 10;
  localparam int DATA_W  = 32;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DBG  = 1'b1
  } port_e;

  // Lanes with their enable set take the new byte; the rest keep the old byte.
  function automatic logic [DATA_W-1:0] be_merge(
    input logic [3:0]        be,
    input logic [DATA_W-1:0] new_word,
    input logic [DATA_W-1:0] old_word
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_grant_sel.sv
// dmem_grant_sel: combinational winner selection, fixed priority with starvation guard or round-robin.
// Revision: 1.0
`default_nettype none

module dmem_grant_sel
  import dmem_pkg::*;
#(
  parameter int PRIO_CORE    = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic [1:0] req_i,
  input  logic [3:0] starve_cnt_i,
  input  port_e      last_gnt_i,
  output logic [1:0] gnt_o
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Each arbitration mode ignores one of the state inputs.
  logic unused_state;
  assign unused_state = ^{starve_cnt_i, last_gnt_i};

  if (PRIO_CORE != 0) begin : g_prio
    always_comb begin
      gnt_o = 2'b00;
      if (req_i[1] && (!req_i[0] || starve_cnt_i == STARVE_MAX)) begin
        gnt_o = 2'b10;
      end else if (req_i[0]) begin
        gnt_o = 2'b01;
      end
    end
  end else begin : g_rr
    always_comb begin
      gnt_o = 2'b00;
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_gnt_i == PORT_DBG) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between core and debug requesters, with byte-lane merging.
// Revision: 1.0
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int PRIO_CORE    = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               m_req,
  input  logic [1:0]               m_we,
  input  logic [1:0][BYTE_AW-1:0]  m_addr,
  input  logic [1:0][3:0]          m_be,
  input  logic [1:0][DATA_W-1:0]   m_wdata,
  output logic [1:0]               m_gnt,
  output logic [1:0]               m_rvalid,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     mem_wr_en,
  output logic                     mem_rd_en,
  output logic [WORD_AW-1:0]       mem_addr,
  output logic [DATA_W-1:0]        mem_w_data,
  input  logic [DATA_W-1:0]        mem_r_data
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  port_e             last_gnt_q, last_gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        sel_gnt;
  logic              win;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m_addr[0][1:0], m_addr[1][1:0]};

  dmem_grant_sel #(
    .PRIO_CORE    (PRIO_CORE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant_sel (
    .req_i        (m_req),
    .starve_cnt_i (starve_cnt_q),
    .last_gnt_i   (last_gnt_q),
    .gnt_o        (sel_gnt)
  );

  // Masking the grant in reset keeps every memory strobe low while rst is high.
  assign m_gnt = rst ? 2'b00 : sel_gnt;

  always_comb begin
    mem_wr_en    = 1'b0;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    mem_w_data   = '0;
    rvalid_d     = 2'b00;
    rdata_d      = rdata_q;
    last_gnt_d   = last_gnt_q;
    starve_cnt_d = starve_cnt_q;
    win          = m_gnt[1];

    if (m_gnt != 2'b00) begin
      last_gnt_d = win ? PORT_DBG : PORT_CORE;
      mem_addr   = m_addr[win][BYTE_AW-1:2];
      if (!m_we[win]) begin
        mem_rd_en = 1'b1;
        rvalid_d  = m_gnt;
        rdata_d   = mem_r_data;
      end else if (m_be[win] == 4'hF) begin
        mem_wr_en  = 1'b1;
        mem_w_data = m_wdata[win];
      end else if (m_be[win] != 4'h0) begin
        // Partial store: read-modify-write through the combinational read port.
        mem_rd_en  = 1'b1;
        mem_wr_en  = 1'b1;
        mem_w_data = be_merge(m_be[win], m_wdata[win], mem_r_data);
      end
    end

    if (!m_req[1] || m_gnt[1]) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      last_gnt_q   <= PORT_DBG;
      rvalid_q     <= 2'b00;
      rdata_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      last_gnt_q   <= last_gnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign m_rvalid = rvalid_q;
  assign m_rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of priority/round-robin arbitration, byte merging and reset behaviour.
// Revision: 1.0
`default_nettype none

module tb_dmem_arbiter;

  logic             clk = 1'b0;
  logic             rst;

  logic [1:0]       m_req, m_we;
  logic [1:0][9:0]  m_addr;
  logic [1:0][3:0]  m_be;
  logic [1:0][31:0] m_wdata;
  logic [1:0]       m_gnt, m_rvalid;
  logic [31:0]      m_rdata;
  logic             mem_wr_en, mem_rd_en;
  logic [7:0]       mem_addr;
  logic [31:0]      mem_w_data, mem_r_data;

  logic [1:0]       rr_req;
  logic [1:0]       rr_we;
  logic [1:0][9:0]  rr_addr;
  logic [1:0][3:0]  rr_be;
  logic [1:0][31:0] rr_wdata;
  logic [1:0]       rr_gnt, rr_rvalid;
  logic [31:0]      rr_rdata;
  logic             rr_wr_en, rr_rd_en;
  logic [7:0]       rr_mem_addr;
  logic [31:0]      rr_w_data;
  logic [31:0]      rr_r_data;

  logic [31:0]      mem [256];
  logic             pre_we;
  logic [7:0]       pre_addr;
  logic [31:0]      pre_data;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  assign mem_r_data = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr_en)   mem[mem_addr] <= mem_w_data;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  dmem_arbiter #(.PRIO_CORE(1), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  dmem_arbiter #(.PRIO_CORE(0), .STARVE_LIMIT(4)) u_rr (
    .clk(clk), .rst(rst), .m_req(rr_req), .m_we(rr_we), .m_addr(rr_addr), .m_be(rr_be),
    .m_wdata(rr_wdata), .m_gnt(rr_gnt), .m_rvalid(rr_rvalid), .m_rdata(rr_rdata),
    .mem_wr_en(rr_wr_en), .mem_rd_en(rr_rd_en), .mem_addr(rr_mem_addr),
    .mem_w_data(rr_w_data), .mem_r_data(rr_r_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic drive(input int p, input logic we, input logic [9:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    m_req[p] = 1'b1; m_we[p] = we; m_addr[p] = a; m_be[p] = be; m_wdata[p] = d;
  endtask

  initial begin
    rst = 1'b1;
    m_req = '0; m_we = '0; m_addr = '0; m_be = '0; m_wdata = '0;
    rr_req = '0; rr_we = '0; rr_addr = '0; rr_be = '0; rr_wdata = '0; rr_r_data = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    tick();
    tick();
    m_req = 2'b01;
    #1;
    chk("rst_gnt", 32'(m_gnt), 32'h0);
    chk("rst_rvalid", 32'(m_rvalid), 32'h0);
    chk("rst_rdata", m_rdata, 32'h0);
    m_req = 2'b00;
    preload(8'd4, 32'hDEADBEEF);
    rst = 1'b0;
    preload(8'd5, 32'h0);
    preload(8'd9, 32'h0);

    // Port 0 load of word 4
    drive(0, 1'b0, 10'h010, 4'h0, 32'h0);
    #1;
    chk("ld_gnt", 32'(m_gnt), 32'h1);
    chk("ld_rd_en", 32'(mem_rd_en), 32'h1);
    chk("ld_addr", 32'(mem_addr), 32'h4);
    tick();
    m_req = 2'b00;
    #1;
    chk("ld_rvalid", 32'(m_rvalid), 32'h1);
    chk("ld_rdata", m_rdata, 32'hDEADBEEF);
    tick();
    chk("ld_rvalid_pulse", 32'(m_rvalid), 32'h0);

    // Partial store from port 1
    preload(8'd4, 32'h11223344);
    drive(1, 1'b1, 10'h010, 4'b0010, 32'h0000AA00);
    #1;
    chk("pst_gnt", 32'(m_gnt), 32'h2);
    chk("pst_strobes", {30'h0, mem_rd_en, mem_wr_en}, 32'h3);
    chk("pst_wdata", mem_w_data, 32'h1122AA44);
    tick();
    chk("pst_mem", mem[4], 32'h1122AA44);
    chk("pst_no_rvalid", 32'(m_rvalid), 32'h0);

    // Zero-enable store is granted but writes nothing
    m_be[1] = 4'h0; m_wdata[1] = 32'hFFFFFFFF;
    #1;
    chk("be0_gnt", 32'(m_gnt), 32'h2);
    chk("be0_wr_en", 32'(mem_wr_en), 32'h0);
    tick();
    m_req = 2'b00;
    chk("be0_mem", mem[4], 32'h1122AA44);

    // Full-word store
    drive(0, 1'b1, 10'h014, 4'hF, 32'h55667788);
    #1;
    chk("fst_strobes", {30'h0, mem_rd_en, mem_wr_en}, 32'h1);
    chk("fst_wdata", mem_w_data, 32'h55667788);
    tick();
    m_req = 2'b00;
    chk("fst_mem", mem[5], 32'h55667788);

    // Starvation guard: both loading continuously -> 0,0,0,0,1 repeating
    drive(0, 1'b0, 10'h010, 4'h0, 32'h0);
    drive(1, 1'b0, 10'h014, 4'h0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("starve_gnt%0d", k), 32'(m_gnt), (k % 5 == 4) ? 32'h2 : 32'h1);
      if (k > 0)
        chk($sformatf("starve_rv%0d", k), 32'(m_rvalid), ((k - 1) % 5 == 4) ? 32'h2 : 32'h1);
      tick();
    end
    m_req = 2'b00;
    tick();

    // Store from port 0, then port 1 reads the same word next cycle
    drive(0, 1'b1, 10'h024, 4'hF, 32'hCAFEF00D);
    tick();
    m_req = 2'b00;
    drive(1, 1'b0, 10'h024, 4'h0, 32'h0);
    #1;
    chk("raw_gnt", 32'(m_gnt), 32'h2);
    tick();
    m_req = 2'b00;
    #1;
    chk("raw_rvalid", 32'(m_rvalid), 32'h2);
    chk("raw_rdata", m_rdata, 32'hCAFEF00D);

    // Reset mid-operation drops the pending response and blocks writes
    drive(0, 1'b0, 10'h010, 4'h0, 32'h0);
    tick();
    #1;
    chk("mrst_pre_rvalid", 32'(m_rvalid), 32'h1);
    rst = 1'b1;
    drive(0, 1'b1, 10'h010, 4'hF, 32'h99999999);
    #1;
    chk("mrst_rvalid", 32'(m_rvalid), 32'h0);
    chk("mrst_rdata", m_rdata, 32'h0);
    chk("mrst_gnt", 32'(m_gnt), 32'h0);
    chk("mrst_wr_en", 32'(mem_wr_en), 32'h0);
    tick();
    chk("mrst_mem", mem[4], 32'h1122AA44);
    m_req = 2'b00;
    rst = 1'b0;
    tick();

    // Round-robin instance
    rr_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_alt%0d", k), 32'(rr_gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    rr_req = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rr_solo%0d", k), 32'(rr_gnt), 32'h1);
      tick();
    end
    // last grant was port 0; reset must restore port 0 as the tie winner
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_req = 2'b11;
    #1;
    chk("rr_after_rst", 32'(rr_gnt), 32'h1);
    tick();
    rr_req = 2'b00;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and byte-lane controller in front of the 256-word data memory. It shares the single memory port between the core load/store path (port 0) and a debug/DMA port (port 1). It converts byte-addressed, byte-enabled requests into whole-word memory accesses; partial stores use the memory's combinational read to merge old and new bytes. Read data returns to the requester through a registered response one cycle after grant.

## Interface
- `PRIO_CORE`, default 1: 1 = fixed priority to port 0 with starvation guard; 0 = round-robin.
- `STARVE_LIMIT`, default 4: consecutive denied cycles after which port 1 is forced a grant (used only when `PRIO_CORE`=1; legal range 1..15).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `m_req[1:0]` input 2: request per port.
- `m_we[1:0]` input 2: 1 = store, 0 = load.
- `m_addr[1:0]` input 2×10: byte address; `[9:2]` is the word index, `[1:0]` is ignored.
- `m_be[1:0]` input 2×4: byte enables for stores; ignored for loads.
- `m_wdata[1:0]` input 2×32: store data, lane-aligned.
- `m_gnt[1:0]` output 2: combinational grant, one-hot or zero.
- `m_rvalid[1:0]` output 2: registered load-response strobe.
- `m_rdata` output 32: registered load data, shared by both ports and qualified by `m_rvalid`.
- `mem_wr_en`, `mem_rd_en` output 1 each: memory strobes.
- `mem_addr` output 8: word address to memory.
- `mem_w_data` output 32: merged write word.
- `mem_r_data` input 32: memory combinational read data.

## Operation
- Each port drives `m_req` high and holds `m_we`, `m_addr`, `m_be` and `m_wdata` stable until it sees `m_gnt`. One access is granted per cycle. A port may issue back-to-back requests.
- Arbitration when `PRIO_CORE`=1:
  - Port 0 wins whenever it requests, unless `starve_cnt` == `STARVE_LIMIT`; in that case port 1 wins.
  - `starve_cnt` is 4 bits. It increments on every cycle where `m_req[1]` is high and port 1 is not granted, and saturates at `STARVE_LIMIT`.
  - `starve_cnt` clears on a port 1 grant, or on any cycle where `m_req[1]` is low.
- Arbitration when `PRIO_CORE`=0:
  - A sole requester wins.
  - If both request, the winner is the port opposite to `last_gnt`.
  - `last_gnt` updates on every grant.
- Granted load: `mem_rd_en`=1, `mem_addr`=`m_addr[9:2]`. `mem_r_data` is captured into `m_rdata`, and `m_rvalid[p]` pulses on the next cycle.
- Granted store with `m_be`=4'hF: `mem_wr_en`=1 and `mem_w_data`=`m_wdata`.
- Granted store with a partial `m_be`: `mem_rd_en`=1 and `mem_wr_en`=1 in the same cycle. Each byte lane of `mem_w_data` takes `m_wdata` where its `m_be` bit is set, otherwise `mem_r_data`.
- Granted store with `m_be`=0: the store is granted and completes, but `mem_wr_en` stays 0.
- Stores produce no `m_rvalid`.
- When no port is granted, all `mem_*` strobes are 0 and `mem_addr`/`mem_w_data` are 0.

## Timing
- Reset values:
  - `m_gnt`=0 while `rst` is high.
  - `m_rvalid`=0, `m_rdata`=0.
  - `starve_cnt`=0.
  - `last_gnt`=1, so port 0 wins the first round-robin tie.
- Latency:
  - Grant is 0 cycles after `m_req`, when the port wins.
  - Store commits at the clock edge that ends the grant cycle.
  - Load data is valid 1 cycle after grant, for exactly 1 cycle.
- Read-after-write: a load granted in the cycle after a store to the same word returns the new data.
- Same-word store from port 0 followed by a load from port 1 in the next cycle: port 1 returns the merged word.
- Asserting `rst` mid-operation drops any pending response. `m_rvalid` goes low asynchronously, and no memory write is issued while `rst` is high.
- `m_rvalid` for both ports is never high in the same cycle.

## Structure
- Shared package `dmem_pkg`:
  - `WORD_AW`=8, `BYTE_AW`=10, `DATA_W`=32.
  - `port_e` enum { `PORT_CORE`=0, `PORT_DBG`=1 }.
  - Function `be_merge(be, new_word, old_word)`.
- One combinational sub-module, `dmem_grant_sel`, holds the priority/round-robin decision and takes `starve_cnt`/`last_gnt` as inputs. All registers stay in `dmem_arbiter`.

## Test plan
- Reset, then port 0 load of addr 0x010 (word 4) preloaded with 0xDEADBEEF -> `m_gnt`=01 in the same cycle; next cycle `m_rvalid`=01 and `m_rdata`=0xDEADBEEF.
- Word 4 = 0x11223344; port 1 store `m_be`=4'b0010, `m_wdata`=0x0000AA00 -> word 4 becomes 0x1122AA44; `m_be`=0 store to it -> no `mem_wr_en`, word unchanged.
- `PRIO_CORE`=1, `STARVE_LIMIT`=4, both ports requesting continuously -> grant pattern 0,0,0,0,1 repeating; `starve_cnt` clears after each port 1 grant.
- `PRIO_CORE`=0, both ports requesting continuously from reset -> grants alternate 0,1,0,1; if port 1 drops, port 0 is granted every cycle.
- Port 0 store of 0xCAFEF00D to word 9, then a port 1 load of word 9 in the next cycle -> `m_rdata`=0xCAFEF00D with `m_rvalid`=10.
- `rst` asserted in the cycle after a load grant -> `m_rvalid` and `m_rdata` go to 0 immediately; after release, arbitration restarts with `last_gnt`=1.
